dircc_node_rx_mailbox_writer: RTL

//  Consumes 16-bit message words from the node's NoC receive stream and writes them into a

---
 rtl/dircc_mailbox_pkg.sv | 29 ++
 rtl/dircc_slot_ring_ctrl.sv | 43 ++++
 rtl/dircc_node_rx_mailbox_writer.sv | 119 +++++++++++
 3 files changed

// File: rtl/dircc_mailbox_pkg.sv
// Shared mailbox definitions: header layout, rx FSM encoding, slot addressing.
// The Nios driver mirrors the header layout when it builds its own messages.
package dircc_mailbox_pkg;

  localparam int ADDR_W        = 14;
  localparam int DATA_W        = 16;
  localparam int HDR_TRUNC_BIT = 15;
  localparam int HDR_LEN_W     = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_COMMIT  = 2'd2
  } rx_state_t;

  // Word address of the header of a slot; payload word i sits at +1+i.
  function automatic logic [ADDR_W-1:0] slot_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [3:0]        slot,
                                                  input int unsigned       slot_words);
    return base + ADDR_W'(32'(slot) * slot_words);
  endfunction

  // Header: truncation flag on top, untruncated payload length below.
  function automatic logic [DATA_W-1:0] make_header(input logic                 trunc,
                                                    input logic [HDR_LEN_W-1:0] len);
    return {trunc, len};
  endfunction

endpackage

// File: rtl/dircc_slot_ring_ctrl.sv
// Slot ring bookkeeping: write/read pointers, committed slot count, full flag
// and the sticky protocol error flag.
module dircc_slot_ring_ctrl
  #(parameter int NUM_SLOTS = 8,
    parameter int PW        = $clog2(NUM_SLOTS))
  (input  logic          clk,
   input  logic          reset,
   input  logic          commit,
   input  logic          slot_release,
   input  logic          proto_err,
   output logic [PW-1:0] wr_slot,
   output logic [PW-1:0] rd_ptr,
   output logic [4:0]    slot_count,
   output logic          full,
   output logic          err_sticky);

  localparam logic [PW-1:0] ONE = PW'(1);

  logic [PW-1:0] wr_ptr;
  logic          rel_ok;

  assign rel_ok  = slot_release & (slot_count != 5'd0);
  // A commit in flight already owns wr_ptr, so a new message must use the next slot.
  assign wr_slot = commit ? wr_ptr + ONE : wr_ptr;
  // Count the in-flight commit so a new message never claims an occupied slot.
  assign full    = ({1'b0, slot_count} + 6'(commit)) >= 6'(NUM_SLOTS);

  // Pointer, count and error flag update; commit and release may coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      slot_count <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (commit) wr_ptr <= wr_ptr + ONE;
      if (rel_ok) rd_ptr <= rd_ptr + ONE;
      slot_count <= slot_count + 5'(commit) - 5'(rel_ok);
      if (proto_err || (slot_release && !rel_ok)) err_sticky <= 1'b1;
    end
  end

endmodule

// File: rtl/dircc_node_rx_mailbox_writer.sv
// Writes NoC receive-stream messages into a ring of mailbox slots in node memory.
// Payload goes first, the header last, so the CPU only ever sees whole messages.
module dircc_node_rx_mailbox_writer
  import dircc_mailbox_pkg::*;
  #(parameter logic [13:0] BASE_ADDR  = 14'h2000,
    parameter int          NUM_SLOTS  = 8,
    parameter int          SLOT_WORDS = 32)
  (input  logic        clk,
   input  logic        reset,
   input  logic        rx_valid,
   output logic        rx_ready,
   input  logic [15:0] rx_data,
   input  logic        rx_sop,
   input  logic        rx_eop,
   output logic [13:0] mem_address,
   output logic        mem_chipselect,
   output logic        mem_write,
   output logic [15:0] mem_writedata,
   output logic [1:0]  mem_byteenable,
   output logic        mem_clken,
   input  logic        slot_release,
   output logic [3:0]  rd_slot,
   output logic [4:0]  slot_count,
   output logic        irq,
   output logic        err_sticky);

  localparam int PW = $clog2(NUM_SLOTS);

  rx_state_t            state;
  logic [PW-1:0]        cur_slot, wr_slot, rd_ptr;
  logic [HDR_LEN_W-1:0] len, len_inc, idx;
  logic                 trunc, commit_pend, full, accept, proto_err, in_slot;
  logic [PW-1:0]        tgt_slot;

  dircc_slot_ring_ctrl #(.NUM_SLOTS(NUM_SLOTS), .PW(PW)) u_ring (
    .clk          (clk),
    .reset        (reset),
    .commit       (commit_pend),
    .slot_release (slot_release),
    .proto_err    (proto_err),
    .wr_slot      (wr_slot),
    .rd_ptr       (rd_ptr),
    .slot_count   (slot_count),
    .full         (full),
    .err_sticky   (err_sticky));

  assign rd_slot        = 4'(rd_ptr);
  assign irq            = slot_count != 5'd0;
  assign mem_chipselect = mem_write;
  assign mem_byteenable = 2'b11;
  assign mem_clken      = 1'b1;
  assign accept         = rx_valid & rx_ready;

  // Stream handshake: only new messages can be held off, mid-message words always flow.
  always_comb begin
    rx_ready = 1'b0;
    case (state)
      ST_IDLE:    rx_ready = !rx_sop || !full;
      ST_PAYLOAD: rx_ready = 1'b1;
      default:    rx_ready = 1'b0;
    endcase
  end

  // Word index, slot fit check and protocol error detection for the incoming word.
  always_comb begin
    idx       = rx_sop ? '0 : len;
    in_slot   = idx < HDR_LEN_W'(SLOT_WORDS - 1);
    len_inc   = (&len) ? len : len + 15'd1;
    tgt_slot  = (state == ST_IDLE) ? wr_slot : cur_slot;
    proto_err = accept && ((rx_sop && state == ST_PAYLOAD) || (!rx_sop && state == ST_IDLE));
  end

  // Receive FSM with registered memory write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      cur_slot      <= '0;
      len           <= '0;
      trunc         <= 1'b0;
      commit_pend   <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
    end else begin
      mem_write   <= 1'b0;
      commit_pend <= 1'b0;
      case (state)
        ST_IDLE, ST_PAYLOAD: begin
          if (accept && (rx_sop || state == ST_PAYLOAD)) begin
            if (rx_sop) begin
              // New message, or restart of a broken one in the same slot.
              cur_slot <= tgt_slot;
              len      <= 15'd1;
              trunc    <= 1'b0;
            end else begin
              len <= len_inc;
              if (!in_slot) trunc <= 1'b1;
            end
            if (in_slot) begin
              mem_write     <= 1'b1;
              mem_address   <= slot_addr(BASE_ADDR, 4'(tgt_slot), SLOT_WORDS) + 14'(idx) + 14'd1;
              mem_writedata <= rx_data;
            end
            state <= rx_eop ? ST_COMMIT : ST_PAYLOAD;
          end
        end
        ST_COMMIT: begin
          mem_write     <= 1'b1;
          mem_address   <= slot_addr(BASE_ADDR, 4'(cur_slot), SLOT_WORDS);
          mem_writedata <= make_header(trunc, len);
          commit_pend   <= 1'b1;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
